// File: rtl/zigzag_pkg.sv
// Shared types, scan-order tables and CAVLC side-information helper for the
// 4x4 zigzag scanner.
package zigzag_pkg;

    localparam int COEFF_MSB = 15;

    typedef logic signed [COEFF_MSB:0] coeff_t;

    typedef struct packed {
        logic [4:0] total_coeff;
        logic [1:0] trailing_ones;
    } cavlc_stats_t;

    localparam logic [3:0] ZIGZAG_FRAME [16] = '{
        4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
    };

    localparam logic [3:0] ZIGZAG_FIELD [16] = '{
        4'd0, 4'd4, 4'd1, 4'd8, 4'd12, 4'd5, 4'd9, 4'd13,
        4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15
    };

    // Takes a scanned block reduced to per-position flags (nonzero, |c|==1) so the
    // helper stays independent of the coefficient width.
    function automatic cavlc_stats_t cavlc_stats(input logic [15:0] nonzero,
                                                 input logic [15:0] unit_mag);
        cavlc_stats_t s;
        logic         stop;
        s.total_coeff   = 5'd0;
        s.trailing_ones = 2'd0;
        stop            = 1'b0;
        for (int k = 15; k >= 0; k--) begin
            if (nonzero[k]) begin
                s.total_coeff = s.total_coeff + 5'd1;
                if (!stop) begin
                    if (!unit_mag[k]) begin
                        stop = 1'b1;
                    end else if (s.trailing_ones != 2'd3) begin
                        s.trailing_ones = s.trailing_ones + 2'd1;
                    end else begin
                        s.trailing_ones = 2'd3;
                    end
                end
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/zigzag_bank.sv
// One buffer bank: all 16 scan-ordered coefficients plus CAVLC stats written at
// once, one coefficient read at a time.
module zigzag_bank
    import zigzag_pkg::*;
#(
    parameter int BIT_LENGTH = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [15:0][BIT_LENGTH:0]  wr_coeffs,
    input  cavlc_stats_t               wr_stats,
    input  logic [3:0]                 rd_pos,
    output logic [BIT_LENGTH:0]        rd_coeff,
    output cavlc_stats_t               rd_stats
);

    logic [15:0][BIT_LENGTH:0] coeffs_r;
    cavlc_stats_t              stats_r;

    // Bank storage, loaded whole on capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            coeffs_r <= '0;
            stats_r  <= '0;
        end else if (wr_en) begin
            coeffs_r <= wr_coeffs;
            stats_r  <= wr_stats;
        end else begin
            coeffs_r <= coeffs_r;
            stats_r  <= stats_r;
        end
    end

    assign rd_coeff = coeffs_r[rd_pos];
    assign rd_stats = stats_r;

endmodule

// File: rtl/zigzag_scan_4x4.sv
// Double-buffered 4x4 zigzag scanner feeding the CAVLC coder.
// Optional field scan order is enabled by defining ZIGZAG_FIELD_SCAN_EN.
module zigzag_scan_4x4
    import zigzag_pkg::*;
#(
    parameter int BIT_LENGTH = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0][BIT_LENGTH:0]  in_block,
`ifdef ZIGZAG_FIELD_SCAN_EN
    input  logic                       field_mode,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [BIT_LENGTH:0] out_coeff,
    output logic [3:0]                 out_pos,
    output logic                       out_last,
    output logic [4:0]                 total_coeff,
    output logic [1:0]                 trailing_ones
);

    logic [1:0] count_r;
    logic [3:0] pos_r;
    logic       wr_sel_r;
    logic       rd_sel_r;

    logic                      capture;
    logic                      beat;
    logic                      last_beat;
    logic [15:0][BIT_LENGTH:0] scanned;
    logic [15:0]               nonzero;
    logic [15:0]               unit_mag;
    cavlc_stats_t              cap_stats;
    logic [BIT_LENGTH:0]       rd_coeff0;
    logic [BIT_LENGTH:0]       rd_coeff1;
    cavlc_stats_t              rd_stats0;
    cavlc_stats_t              rd_stats1;
    cavlc_stats_t              out_stats;

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign capture   = in_valid && in_ready;
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && (pos_r == 4'd15);

    // Reorder at capture so the banks hold coefficients already in scan order.
    for (genvar k = 0; k < 16; k++) begin : g_scan
        logic [3:0] src;
`ifdef ZIGZAG_FIELD_SCAN_EN
        assign src = field_mode ? ZIGZAG_FIELD[k] : ZIGZAG_FRAME[k];
`else
        assign src = ZIGZAG_FRAME[k];
`endif
        assign scanned[k]  = in_block[src];
        assign nonzero[k]  = |scanned[k];
        // |c|==1 by equality against +1 and -1: no negation, no overflow at the minimum.
        assign unit_mag[k] = (scanned[k] == {{BIT_LENGTH{1'b0}}, 1'b1}) ||
                             (scanned[k] == {(BIT_LENGTH + 1){1'b1}});
    end

    assign cap_stats = cavlc_stats(nonzero, unit_mag);

    zigzag_bank #(.BIT_LENGTH(BIT_LENGTH)) bank0 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (capture && !wr_sel_r),
        .wr_coeffs (scanned),
        .wr_stats  (cap_stats),
        .rd_pos    (pos_r),
        .rd_coeff  (rd_coeff0),
        .rd_stats  (rd_stats0)
    );

    zigzag_bank #(.BIT_LENGTH(BIT_LENGTH)) bank1 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (capture && wr_sel_r),
        .wr_coeffs (scanned),
        .wr_stats  (cap_stats),
        .rd_pos    (pos_r),
        .rd_coeff  (rd_coeff1),
        .rd_stats  (rd_stats1)
    );

    // Bank pointers, read position and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r  <= 2'd0;
            pos_r    <= 4'd0;
            wr_sel_r <= 1'b0;
            rd_sel_r <= 1'b0;
        end else begin
            wr_sel_r <= capture   ? ~wr_sel_r : wr_sel_r;
            pos_r    <= beat      ? pos_r + 4'd1 : pos_r;
            rd_sel_r <= last_beat ? ~rd_sel_r : rd_sel_r;
            case ({capture, last_beat})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Output mux; zeros while empty so reset state is clean regardless of bank contents.
    always_comb begin
        out_coeff = '0;
        out_stats = '0;
        if (out_valid) begin
            if (rd_sel_r) begin
                out_coeff = rd_coeff1;
                out_stats = rd_stats1;
            end else begin
                out_coeff = rd_coeff0;
                out_stats = rd_stats0;
            end
        end else begin
            out_coeff = '0;
            out_stats = '0;
        end
    end

    assign out_pos       = pos_r;
    assign out_last      = out_valid && (pos_r == 4'd15);
    assign total_coeff   = out_stats.total_coeff;
    assign trailing_ones = out_stats.trailing_ones;

endmodule

// File: tb/tb_zigzag_scan_4x4.sv
// Self-checking bench for zigzag_scan_4x4: directed vector table plus random
// traffic against a queue-based reference model.
module tb_zigzag_scan_4x4;

    typedef logic [15:0][15:0] blk_t;

    typedef struct {
        logic signed [15:0] coeff;
        int                 pos;
        int                 tc;
        int                 t1;
    } beat_t;

    typedef struct {
        blk_t blk;
        int   seq [16];
        int   tc;
        int   t1;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    blk_t               in_block;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_coeff;
    logic [3:0]         out_pos;
    logic               out_last;
    logic [4:0]         total_coeff;
    logic [1:0]         trailing_ones;
`ifdef ZIGZAG_FIELD_SCAN_EN
    logic               field_mode = 1'b0;
`endif

    int    checks = 0;
    int    errors = 0;
    int    occ = 0;
    beat_t exp_q[$];
    int    frame_order [16];
    int    field_order [16] = '{0, 4, 1, 8, 12, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    vec_t  vecs [7];
    bit    sending_done;

    always #5 clk = ~clk;

    zigzag_scan_4x4 #(.BIT_LENGTH(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_block      (in_block),
`ifdef ZIGZAG_FIELD_SCAN_EN
        .field_mode    (field_mode),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_coeff     (out_coeff),
        .out_pos       (out_pos),
        .out_last      (out_last),
        .total_coeff   (total_coeff),
        .trailing_ones (trailing_ones)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Zigzag order derived from anti-diagonals: odd diagonals walk down-left, even up-right.
    function automatic void build_frame_order();
        int n = 0;
        for (int s = 0; s <= 6; s++) begin
            for (int j = 0; j < 4; j++) begin
                int r = (s % 2 == 1) ? j : 3 - j;
                int c = s - r;
                if (c >= 0 && c < 4) begin
                    frame_order[n] = r * 4 + c;
                    n++;
                end
            end
        end
    endfunction

    function automatic void model_push(input blk_t b, input bit fm);
        int v [16];
        int nz[$];
        int tc;
        int t1 = 0;
        for (int k = 0; k < 16; k++) begin
            v[k] = $signed(b[fm ? field_order[k] : frame_order[k]]);
            if (v[k] != 0) nz.push_back(v[k]);
        end
        tc = nz.size();
        while (nz.size() > 0 && t1 < 3 && (nz[$] == 1 || nz[$] == -1)) begin
            t1++;
            void'(nz.pop_back());
        end
        for (int k = 0; k < 16; k++) begin
            beat_t e;
            e.coeff = v[k][15:0];
            e.pos   = k;
            e.tc    = tc;
            e.t1    = t1;
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: compares every cycle against the model, then advances it as the edge will.
    always @(negedge clk) begin
        bit cap;
        bit bt;
        bit lst;
        bit fm = 1'b0;
`ifdef ZIGZAG_FIELD_SCAN_EN
        fm = field_mode;
`endif
        if (!reset) begin
            exp_q.delete();
            occ = 0;
        end else begin
            chk("out_valid", out_valid, occ != 0);
            chk("in_ready", in_ready, occ != 2);
            if (occ != 0 && exp_q.size() > 0) begin
                chk("coeff", out_coeff, exp_q[0].coeff);
                chk("pos", out_pos, exp_q[0].pos);
                chk("last", out_last, exp_q[0].pos == 15);
                chk("total_coeff", total_coeff, exp_q[0].tc);
                chk("trailing_ones", trailing_ones, exp_q[0].t1);
            end
            cap = in_valid && occ != 2;
            bt  = out_ready && occ != 0 && exp_q.size() > 0;
            lst = bt && exp_q[0].pos == 15;
            if (bt) void'(exp_q.pop_front());
            if (cap) model_push(in_block, fm);
            occ = occ + int'(cap) - int'(lst);
        end
    end

    task automatic send_block(input blk_t b, input bit fm);
        bit acc = 1'b0;
        in_block = b;
        in_valid = 1'b1;
`ifdef ZIGZAG_FIELD_SCAN_EN
        field_mode = fm;
`endif
        for (int t = 0; t < 400 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 200 && !idle; t++) begin
            @(negedge clk);
            idle = !out_valid;
        end
        @(posedge clk);
        #1;
        if (!idle) chk("idle_timeout", 0, 1);
    endtask

    task automatic run_vec(input vec_t v, input bit fm);
        wait_idle();
        send_block(v.blk, fm);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_coeff", out_coeff, v.seq[k]);
            chk("tbl_last", out_last, k == 15);
            chk("tbl_total_coeff", total_coeff, v.tc);
            chk("tbl_trailing_ones", trailing_ones, v.t1);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    b[i] = 16'h0000;
                2:       b[i] = 16'h0001;
                3:       b[i] = 16'hFFFF;
                4:       b[i] = 16'hFFFE;
                default: b[i] = 16'($urandom);
            endcase
        end
        return b;
    endfunction

    task automatic random_run(input int nblk, input bit stall);
        sending_done = 1'b0;
        wait_idle();
        fork
            begin
                for (int b = 0; b < nblk; b++) send_block(rand_blk(), 1'b0);
                sending_done = 1'b1;
            end
            begin
                for (int c = 0; c < 3000; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                    if (sending_done && exp_q.size() == 0) break;
                end
            end
        join
        wait_idle();
    endtask

    initial begin
        build_frame_order();
        for (int n = 0; n < 7; n++) begin
            vecs[n].blk = '0;
            vecs[n].tc  = 0;
            vecs[n].t1  = 0;
            for (int k = 0; k < 16; k++) vecs[n].seq[k] = 0;
        end
        for (int i = 0; i < 16; i++) vecs[0].blk[i] = 16'(i + 1);
        vecs[0].seq = '{1, 2, 5, 9, 6, 3, 4, 7, 10, 13, 14, 11, 8, 12, 15, 16};
        vecs[0].tc  = 16;
        vecs[1].blk[0] = 16'd7;  vecs[1].blk[5] = 16'hFFFF;
        vecs[1].blk[2] = 16'd1;  vecs[1].blk[15] = 16'hFFFF;
        vecs[1].seq = '{7, 0, 0, 0, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
        vecs[1].tc  = 4;  vecs[1].t1 = 3;
        vecs[2].blk[0] = 16'd1;  vecs[2].blk[1] = 16'd1;
        vecs[2].blk[4] = 16'hFFFF; vecs[2].blk[8] = 16'd1;
        vecs[2].seq = '{1, 1, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].tc  = 4;  vecs[2].t1 = 3;
        vecs[4].blk[0] = 16'd1;  vecs[4].blk[15] = 16'h8000;
        vecs[4].seq = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -32768};
        vecs[4].tc  = 2;
        vecs[5].blk[3] = 16'hFFFF; vecs[5].blk[6] = 16'd2;
        vecs[5].seq = '{0, 0, 0, 0, 0, 0, -1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5].tc  = 2;
        vecs[6].blk[1] = 16'd3;  vecs[6].blk[12] = 16'hFFFF; vecs[6].blk[13] = 16'd1;
        vecs[6].seq = '{0, 3, 0, 0, 0, 0, 0, 0, 0, -1, 1, 0, 0, 0, 0, 0};
        vecs[6].tc  = 3;  vecs[6].t1 = 2;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_pos", out_pos, 0);
        chk("rst_out_coeff", out_coeff, 0);
        chk("rst_total_coeff", total_coeff, 0);
        chk("rst_trailing_ones", trailing_ones, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int n = 0; n < 7; n++) run_vec(vecs[n], 1'b0);

        // Three blocks back to back: the third waits for the first to finish draining.
        wait_idle();
        send_block(vecs[0].blk, 1'b0);
        send_block(vecs[1].blk, 1'b0);
        @(negedge clk);
        chk("b2b_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        send_block(vecs[6].blk, 1'b0);
        wait_idle();

        random_run(10, 1'b0);
        random_run(12, 1'b1);

        // Reset in the middle of a block, then a clean block afterwards.
        wait_idle();
        send_block(vecs[0].blk, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_pos", out_pos, 0);
        chk("midrst_out_coeff", out_coeff, 0);
        chk("midrst_total_coeff", total_coeff, 0);
        @(posedge clk);
        #1;
        run_vec(vecs[1], 1'b0);

`ifdef ZIGZAG_FIELD_SCAN_EN
        begin
            vec_t fv;
            for (int i = 0; i < 16; i++) begin
                fv.blk[i] = 16'(i);
                fv.seq[i] = field_order[i];
            end
            fv.tc = 15;
            fv.t1 = 0;
            run_vec(fv, 1'b1);
            field_mode = 1'b0;
        end
`endif

        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zigzag_scan_4x4.md
Name: zigzag_scan_4x4

Overview:
- Stage directly downstream of the 4x4 quantizer. Captures one quantized 4x4 block (16 parallel signed coefficients) per valid/ready handshake.
- Emits the coefficients serially, one per cycle, in zigzag scan order, toward the CAVLC entropy coder.
- Double-buffered: one block can be captured while the previous one drains.
- Computes per-block CAVLC side information (TotalCoeff, TrailingOnes) when the block is captured.

Parameters:
- BIT_LENGTH, 15, MSB index of each coefficient; coefficient width is BIT_LENGTH+1 bits, signed.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  in_block holds a valid quantized block.
- in_ready  out  1  block can be accepted this cycle.
- in_block  in  16 x (BIT_LENGTH+1)  signed coefficients, raster row-major, index = row*4+col.
- out_valid  out  1  out_coeff is valid.
- out_ready  in  1  downstream accepts the current beat.
- out_coeff  out  BIT_LENGTH+1  signed coefficient at the current scan position.
- out_pos  out  4  scan position 0..15.
- out_last  out  1  high on scan position 15.
- total_coeff  out  5  nonzero count of the draining block, 0..16; stable for all 16 beats.
- trailing_ones  out  2  CAVLC TrailingOnes of the draining block, 0..3; stable for all 16 beats.

Behaviour:
- Frame zigzag order (raster indices): 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- Storage: two banks, each holding 16 coefficients plus total_coeff and trailing_ones, stored already in scan order.
- Counters:
  - wr_sel and rd_sel: 1-bit bank pointers.
  - count: 0..2 full banks.
  - pos: 4-bit read position.
- in_ready = (count != 2).
- Capture happens on in_valid && in_ready:
  - write bank wr_sel in scan order;
  - latch total_coeff = number of nonzero coefficients;
  - latch trailing_ones = consecutive ±1 values counted from the highest scan position downward, skipping zeros, stopping at the first nonzero with |c|>1, saturating at 3;
  - toggle wr_sel.
- out_valid = (count != 0).
- out_coeff and out_pos are read combinationally from bank rd_sel at pos.
- On out_valid && out_ready: pos increments. At pos 15 the beat has out_last=1, pos wraps to 0, and rd_sel toggles.
- count updates: +1 on capture only, −1 on final beat only, unchanged when both happen in the same cycle. The same bank cannot be both written and read in one cycle, because a capture requires count<2.
- Latency: a block captured at edge N gives out_valid=1 in cycle N+1 with pos 0, provided count was 0.
- Throughput: 16 beats per block; back-to-back blocks have no bubble while out_ready stays high.
- Backpressure: while out_ready=0, out_coeff, out_pos, out_last, total_coeff and trailing_ones hold constant.
- All-zero block: still emits 16 beats, with total_coeff=0 and trailing_ones=0.
- Reset (also mid-block):
  - count=0, pos=0, wr_sel=0, rd_sel=0;
  - out_valid=0, out_last=0, in_ready=1;
  - out_coeff=0, out_pos=0, total_coeff=0, trailing_ones=0;
  - the partially drained block is discarded, and bank contents are don't-care.
- Arithmetic: coefficients pass through unchanged. |c|==1 is tested as c==1 or c==−1, so no negation is needed and no overflow is possible at −2^BIT_LENGTH.

Optional Feature:
- Macro: ZIGZAG_FIELD_SCAN_EN.
- When defined:
  - extra input port field_mode (1 bit), sampled at capture and stored per bank;
  - field_mode=1 selects field scan order 0,4,1,8,12,5,9,13,2,6,10,14,3,7,11,15;
  - trailing_ones and total_coeff are computed in the selected order.
- When undefined: no field_mode port; frame order only.

Decomposition:
- Package zigzag_pkg holds:
  - coeff_t (signed BIT_LENGTH+1);
  - ZIGZAG_FRAME[16] and ZIGZAG_FIELD[16] constant index arrays;
  - function cavlc_stats(scanned block) returning total_coeff and trailing_ones.
- One sub-module, zigzag_bank, is natural: a single buffer bank with write-all / read-one access, instantiated twice.

Test Plan:
- Block with in_block[i]=i+1, out_ready=1 → 16 beats with out_coeff = 1,2,5,9,6,3,4,7,10,13,14,11,8,12,15,16; out_last on beat 16; total_coeff=16, trailing_ones=0; out_valid first seen the cycle after capture.
- Raster block, all zero except [0]=7, [5]=−1, [2]=1, [15]=−1 → total_coeff=4, trailing_ones=3. Variant [0]=1, [1]=1, [4]=−1, [8]=1, all else 0 → trailing_ones=3 (saturated).
- Three blocks offered back-to-back with out_ready=1 → in_ready drops to 0 after the second capture and returns on the first block's last beat; 48 contiguous output beats, no bubbles.
- out_ready toggled randomly, 1 cycle in 3 low → outputs stable while stalled; coefficient sequence identical to the unstalled run.
- Assert reset low at beat 7 of a block, release after one cycle → out_valid=0 and in_ready=1 on the first cycle after release; the next block starts at out_pos=0 with correct data.
- With ZIGZAG_FIELD_SCAN_EN and field_mode=1, in_block[i]=i → out_coeff = 0,4,1,8,12,5,9,13,2,6,10,14,3,7,11,15.
